// File: rtl/operand_fetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// operand_fetch
//
// Operand-fetch stage between decode and issue. Accepts decoded instructions,
// drives the two synchronous register-file read ports, tracks in-flight
// destination registers in a 32-entry scoreboard, stalls on RAW/WAW hazards
// and presents the instruction plus operands to issue over valid/ready.
//
// Two stages:
//   F1 - combinational accept, read strobes issued to the register file
//   F2 - output register; operands come from the register-file data (valid
//        one cycle after the strobe) or from a captured forward value
//
// Optional feature (compile-time macro):
//   OPERAND_FETCH_BYPASS_EN - same-cycle write-back forwarding. A write to a
//   pending register releases the hazard in the same cycle and the write data
//   is captured into F2 in place of the (stale) register-file data.
//
// Ports:
//   clk_i, resetb_i        clock, asynchronous active-low reset
//   clk_en_i               global clock enable (low freezes all state)
//   dec_*                  decode-side handshake, sources, destination, payload
//   rreg_a_* / rreg_b_*    register-file read ports (a = rs1, b = rs2)
//   wreg_a_* / wreg_b_*    write-back snoop (same nets as the register file)
//   iss_*                  issue-side handshake, operands, destination, payload
//   kill_i                 flush: drop F2 and clear the scoreboard
// ---------------------------------------------------------------------------
module operand_fetch #(
  parameter int P_XLEN    = 32,
  parameter int P_PAYLOAD = 32
) (
  input  logic                 clk_i,
  input  logic                 resetb_i,
  input  logic                 clk_en_i,
  // decode
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [4:0]           dec_rs1_addr_i,
  input  logic [4:0]           dec_rs2_addr_i,
  input  logic                 dec_rs1_used_i,
  input  logic                 dec_rs2_used_i,
  input  logic [4:0]           dec_rd_addr_i,
  input  logic                 dec_rd_wr_i,
  input  logic [P_PAYLOAD-1:0] dec_payload_i,
  // register-file read ports
  output logic                 rreg_a_rd_o,
  output logic [4:0]           rreg_a_addr_o,
  input  logic [P_XLEN-1:0]    rreg_a_data_i,
  output logic                 rreg_b_rd_o,
  output logic [4:0]           rreg_b_addr_o,
  input  logic [P_XLEN-1:0]    rreg_b_data_i,
  // write-back snoop
  input  logic                 wreg_a_wr_i,
  input  logic [4:0]           wreg_a_addr_i,
  input  logic [P_XLEN-1:0]    wreg_a_data_i,
  input  logic                 wreg_b_wr_i,
  input  logic [4:0]           wreg_b_addr_i,
  input  logic [P_XLEN-1:0]    wreg_b_data_i,
  // issue
  output logic                 iss_valid_o,
  input  logic                 iss_ready_i,
  output logic [P_XLEN-1:0]    iss_rs1_data_o,
  output logic [P_XLEN-1:0]    iss_rs2_data_o,
  output logic [4:0]           iss_rd_addr_o,
  output logic                 iss_rd_wr_o,
  output logic [P_PAYLOAD-1:0] iss_payload_o,
  // flush
  input  logic                 kill_i
);

  // F2 state
  logic                 f2_valid_q;
  logic                 f2_rs1_act_q;
  logic                 f2_rs2_act_q;
  logic [4:0]           f2_rd_addr_q;
  logic                 f2_rd_wr_q;
  logic [P_PAYLOAD-1:0] f2_payload_q;

  // scoreboard: one bit per architectural register with a writer in flight
  logic [31:0] pending_q;
  logic [31:0] pending_d;

  logic [31:0] wr_clr;
  logic [31:0] busy;
  logic        rs1_act;
  logic        rs2_act;
  logic        rd_act;
  logic        f2_rd_act;
  logic        hazard;
  logic        accept;
  logic        handoff;

  // x0 is never a real source or destination
  assign rs1_act   = dec_rs1_used_i && (dec_rs1_addr_i != 5'd0);
  assign rs2_act   = dec_rs2_used_i && (dec_rs2_addr_i != 5'd0);
  assign rd_act    = dec_rd_wr_i && (dec_rd_addr_i != 5'd0);
  assign f2_rd_act = f2_rd_wr_q && (f2_rd_addr_q != 5'd0);

  // registers written back this cycle on either snoop port
  always_comb begin
    wr_clr = '0;
    if (wreg_a_wr_i && (wreg_a_addr_i != 5'd0)) wr_clr[wreg_a_addr_i] = 1'b1;
    if (wreg_b_wr_i && (wreg_b_addr_i != 5'd0)) wr_clr[wreg_b_addr_i] = 1'b1;
  end

  // Registers that cannot be read or written yet. The producer still sitting
  // in F2 has not set its pending bit, so it is folded in here directly.
  always_comb begin
`ifdef OPERAND_FETCH_BYPASS_EN
    busy = pending_q & ~wr_clr;
`else
    busy = pending_q;
`endif
    if (f2_valid_q && f2_rd_act) busy[f2_rd_addr_q] = 1'b1;
  end

  // one rule covers RAW on both sources and WAW on the destination
  assign hazard = (rs1_act && busy[dec_rs1_addr_i]) ||
                  (rs2_act && busy[dec_rs2_addr_i]) ||
                  (rd_act  && busy[dec_rd_addr_i]);

  assign dec_ready_o = resetb_i && clk_en_i && !kill_i &&
                       (!f2_valid_q || iss_ready_i) && !hazard;
  assign accept      = dec_valid_i && dec_ready_o;
  assign handoff     = f2_valid_q && iss_ready_i && clk_en_i;

  assign rreg_a_rd_o   = accept && dec_rs1_used_i;
  assign rreg_b_rd_o   = accept && dec_rs2_used_i;
  assign rreg_a_addr_o = dec_rs1_addr_i;
  assign rreg_b_addr_o = dec_rs2_addr_i;

  // set on handoff wins over a same-cycle clear of the same register
  always_comb begin
    pending_d = pending_q & ~wr_clr;
    if (handoff && f2_rd_act) pending_d[f2_rd_addr_q] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      f2_valid_q   <= 1'b0;
      f2_rs1_act_q <= 1'b0;
      f2_rs2_act_q <= 1'b0;
      f2_rd_addr_q <= '0;
      f2_rd_wr_q   <= 1'b0;
      f2_payload_q <= '0;
      pending_q    <= '0;
    end else if (clk_en_i) begin
      if (kill_i) begin
        f2_valid_q <= 1'b0;
        pending_q  <= '0;
      end else begin
        pending_q <= pending_d;
        if (accept) begin
          f2_valid_q   <= 1'b1;
          f2_rs1_act_q <= rs1_act;
          f2_rs2_act_q <= rs2_act;
          f2_rd_addr_q <= dec_rd_addr_i;
          f2_rd_wr_q   <= dec_rd_wr_i;
          f2_payload_q <= dec_payload_i;
        end else if (handoff) begin
          f2_valid_q <= 1'b0;
        end
      end
    end
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [P_XLEN-1:0] fwd1_data;
  logic [P_XLEN-1:0] fwd2_data;
  logic              f2_fwd1_q;
  logic              f2_fwd2_q;
  logic [P_XLEN-1:0] f2_fwd1_data_q;
  logic [P_XLEN-1:0] f2_fwd2_data_q;

  // The register file returns the pre-write value on a same-cycle read, so
  // the write data is taken from the snoop instead. Port b is checked last
  // so it wins when both ports hit the same register.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (rs1_act && wreg_a_wr_i && (wreg_a_addr_i == dec_rs1_addr_i)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = wreg_a_data_i;
    end
    if (rs1_act && wreg_b_wr_i && (wreg_b_addr_i == dec_rs1_addr_i)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = wreg_b_data_i;
    end
    if (rs2_act && wreg_a_wr_i && (wreg_a_addr_i == dec_rs2_addr_i)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = wreg_a_data_i;
    end
    if (rs2_act && wreg_b_wr_i && (wreg_b_addr_i == dec_rs2_addr_i)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = wreg_b_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      f2_fwd1_q      <= 1'b0;
      f2_fwd2_q      <= 1'b0;
      f2_fwd1_data_q <= '0;
      f2_fwd2_data_q <= '0;
    end else if (clk_en_i && !kill_i && accept) begin
      f2_fwd1_q      <= fwd1_hit;
      f2_fwd2_q      <= fwd2_hit;
      f2_fwd1_data_q <= fwd1_data;
      f2_fwd2_data_q <= fwd2_data;
    end
  end

  assign iss_rs1_data_o = f2_fwd1_q ? f2_fwd1_data_q :
                          (f2_rs1_act_q ? rreg_a_data_i : '0);
  assign iss_rs2_data_o = f2_fwd2_q ? f2_fwd2_data_q :
                          (f2_rs2_act_q ? rreg_b_data_i : '0);
`else
  // write data is only needed for forwarding
  logic unused_wdata;
  assign unused_wdata = ^{wreg_a_data_i, wreg_b_data_i};

  assign iss_rs1_data_o = f2_rs1_act_q ? rreg_a_data_i : '0;
  assign iss_rs2_data_o = f2_rs2_act_q ? rreg_b_data_i : '0;
`endif

  assign iss_valid_o   = f2_valid_q;
  assign iss_rd_addr_o = f2_rd_addr_q;
  assign iss_rd_wr_o   = f2_rd_wr_q;
  assign iss_payload_o = f2_payload_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage between decode and issue, the initiator side of the integer register file. It accepts decoded instructions, drives the register file's two synchronous read ports, and tracks in-flight destination registers in a 32-entry scoreboard. It stalls on RAW/WAW hazards, snoops both write-back ports for optional same-cycle forwarding, and presents the instruction with its operands to issue over a valid/ready handshake.

## Interface
- P_XLEN, 32, register width
- P_PAYLOAD, 32, opaque decode payload width carried with the instruction
- clk_i  in  1  clock
- resetb_i  in  1  asynchronous active-low reset
- clk_en_i  in  1  global clock enable; when low, all state is frozen
- dec_valid_i / dec_ready_o  in/out  1  decode handshake
- dec_rs1_addr_i, dec_rs2_addr_i  in  5  source addresses
- dec_rs1_used_i, dec_rs2_used_i  in  1  source is read
- dec_rd_addr_i  in  5; dec_rd_wr_i  in  1  destination
- dec_payload_i  in  P_PAYLOAD  opaque payload
- rreg_a_rd_o, rreg_b_rd_o  out  1  register-file read strobes (a=rs1, b=rs2)
- rreg_a_addr_o, rreg_b_addr_o  out  5  read addresses
- rreg_a_data_i, rreg_b_data_i  in  P_XLEN  read data, valid one cycle after strobe, held until next strobe
- wreg_a_wr_i, wreg_b_wr_i  in  1; wreg_a/b_addr_i  in  5; wreg_a/b_data_i  in  P_XLEN  write-back snoop (same nets as the register file)
- iss_valid_o / iss_ready_i  out/in  1  issue handshake
- iss_rs1_data_o, iss_rs2_data_o  out  P_XLEN; iss_rd_addr_o  out  5; iss_rd_wr_o  out  1; iss_payload_o  out  P_PAYLOAD
- kill_i  in  1  flush: drop the F2 entry and clear the scoreboard

## Operation
- Two stages: F1 (accept, read strobe) and F2 (output register, iss_valid_o).
- Active source: used && addr != 0. Active destination: rd_wr && rd != 0. Address 0 is never pending and never forwarded.
- Hazard on an active source or destination address X when pending[X] is set and X is not cleared by a write this cycle, or when F2 is valid with an active destination equal to X.
- A write clears pending[X] this cycle only with bypass compiled in. WAW is handled by the same rule, so at most one writer is in flight per register.
- dec_ready_o = clk_en_i && !kill_i && (!F2 valid || iss_ready_i) && !hazard. Combinational; it is computed from the decode inputs.
- Accept = dec_valid_i && dec_ready_o. rreg_a_rd_o = accept && rs1 used; rreg_b_rd_o = accept && rs2 used. The read addresses are passed through from decode.
- Operand output selection:
  - forwarded value, if it was captured at accept;
  - else register-file data, if the source is active;
  - else 0.
- Handoff = iss_valid_o && iss_ready_i && clk_en_i. On handoff with an active destination, set pending[rd].
- Any write on a port with addr != 0 clears pending[addr].
- Set and clear of the same address in one cycle: set wins.
- Both write ports on the same address in one cycle: port b data wins for forwarding.
- kill_i (with clk_en_i): F2 valid <= 0 and pending <= 0. No accept and no pending set happen that cycle. The owner asserts kill_i only when all downstream work is also flushed.
- Reset values: iss_valid_o 0, all iss_* data 0, pending all 0, forward flags 0. rreg_*_rd_o and dec_ready_o are 0 while resetb_i is low.

## Timing
- Accept at edge N → iss_valid_o and operands at N+1. Throughput is one instruction per cycle with iss_ready_i high.
- While iss_valid_o && !iss_ready_i: all iss_* outputs are stable, no read strobes are issued, and no accept happens.
- A RAW consumer is accepted in the same cycle as the producer's write-back with bypass, or one cycle later without it.
- clk_en_i low: no state change, dec_ready_o 0, read strobes 0, outputs held.
- Reset assertion mid-operation drops F2 and the scoreboard immediately (asynchronous).

## Configuration
- OPERAND_FETCH_BYPASS_EN defined: same-cycle write-back forwarding is enabled.
  - A write to X releases a hazard on X in that cycle.
  - The write data is captured into F2 in place of the register-file data, which returns the old value.
- Undefined: no forward registers or muxes. The hazard holds until pending[X] is cleared, and the consumer is accepted the following cycle, reading the committed value.

## Test plan
- Reset with dec_valid_i=1 (rs1=x1, rs2=x2) → iss_valid_o=0 during reset. dec_ready_o=1 after reset; iss_valid_o=1 next cycle with the register-file data for x1/x2.
- Sources x0 and an unused rs2, with the register-file read ports holding 0xFFFFFFFF → iss_rs1_data_o=0, iss_rs2_data_o=0, rreg_b_rd_o never asserted.
- Producer with rd=x5 handed off, consumer reads x5 → dec_ready_o=0. wreg_a writes x5=0xDEADBEEF at cycle N:
  - bypass: accept at N, iss_rs1_data_o=0xDEADBEEF at N+1;
  - no bypass: accept at N+1, data 0xDEADBEEF at N+2.
- iss_ready_i low for 3 cycles with F2 valid → outputs unchanged, dec_ready_o=0, no read strobes. A single handoff follows when iss_ready_i rises.
- Pending x7, wreg_a writes x7=1 and wreg_b writes x7=2 in the same cycle → pending[x7] cleared; with bypass the forwarded operand is 2.
- F2 valid and pending x3, kill_i pulse → iss_valid_o=0 next cycle. A following instruction reading x3 is accepted immediately.
